cs_stream_feeder: RTL and testbench

- Producer-side front end for the 3x3 compressed-sensing filter datapath (the `CS` module: 8-bit sample X in, 10-bit Y out).
- Accepts 8-bit samples from an upstream valid/ready source into a small FIFO.
- Streams them to the filter's X input one per clock, gap-free, because the filter window shifts every clock and has no stall.
- Tracks window fill, drives the filter reset on underrun, and returns each valid 10-bit Y result with a valid strobe and sequence index.

---
 rtl/cs_stream_feeder.sv | 139 +++++++++++++
 tb/tb_cs_stream_feeder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cs_stream_feeder.sv
// cs_stream_feeder: small FIFO front end that feeds the 3x3 CS filter one sample
// per clock without gaps, restarts the filter on underrun and returns each valid
// filter result with a one-cycle strobe and a running result index.
module cs_stream_feeder #(
  parameter int DEPTH       = 16,
  parameter int START_LEVEL = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  cs_x,
  output logic        cs_rst,
  input  logic [9:0]  cs_y,
  output logic [9:0]  out_y,
  output logic        out_valid,
  output logic [15:0] out_idx,
  output logic [7:0]  underrun_cnt,
  output logic        streaming
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] START_LVL = (AW + 1)'(START_LEVEL);
  // The filter window holds nine samples; results are meaningful from the 9th on.
  localparam logic [3:0]  FILL_MAX  = 4'd9;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic [3:0]  fill_q, fill_d;
  logic [7:0]  underrun_cnt_q, underrun_cnt_d;
  logic        cap_pend_q, cap_pend_d;
  logic [9:0]  out_y_q, out_y_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_idx_q, out_idx_d;

  logic        empty_s, full_s, push_s, pop_s;
  logic [AW:0] count_s;
  logic [7:0]  cs_x_s;

  // Pointer-compare FIFO status; the extra wrap bit separates full from empty.
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_s = wr_ptr_q - rd_ptr_q;
  assign push_s  = in_valid && !full_s && !reset;

  // Next-state, FIFO pop, window fill tracking and result capture.
  always_comb begin
    state_d        = state_q;
    fill_d         = fill_q;
    underrun_cnt_d = underrun_cnt_q;
    cap_pend_d     = 1'b0;
    pop_s          = 1'b0;
    cs_x_s         = 8'd0;
    // A sample flagged last cycle has its filter output on cs_y now.
    out_valid_d    = cap_pend_q;
    out_y_d        = cap_pend_q ? cs_y : out_y_q;
    // The index advances only after the strobed result has been presented.
    out_idx_d      = out_valid_q ? (out_idx_q + 16'd1) : out_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (count_s >= START_LVL) begin
          state_d = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (!empty_s) begin
          pop_s      = 1'b1;
          cs_x_s     = mem_q[rd_ptr_q[AW-1:0]];
          fill_d     = (fill_q == FILL_MAX) ? FILL_MAX : (fill_q + 4'd1);
          cap_pend_d = (fill_q >= (FILL_MAX - 4'd1));
        end else begin
          // Underrun: the filter window is broken, so restart from scratch.
          state_d        = ST_IDLE;
          fill_d         = 4'd0;
          underrun_cnt_d = (underrun_cnt_q == 8'd255) ? 8'd255 : (underrun_cnt_q + 8'd1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        fill_d  = 4'd0;
      end
    endcase
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_s};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_s};
  end

  // Control and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fill_q         <= 4'd0;
      underrun_cnt_q <= 8'd0;
      cap_pend_q     <= 1'b0;
      out_y_q        <= 10'd0;
      out_valid_q    <= 1'b0;
      out_idx_q      <= 16'd0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fill_q         <= fill_d;
      underrun_cnt_q <= underrun_cnt_d;
      cap_pend_q     <= cap_pend_d;
      out_y_q        <= out_y_d;
      out_valid_q    <= out_valid_d;
      out_idx_q      <= out_idx_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

  assign in_ready     = !full_s && !reset;
  assign cs_x         = cs_x_s;
  assign cs_rst       = (state_q == ST_IDLE) || reset;
  assign out_y        = out_y_q;
  assign out_valid    = out_valid_q;
  assign out_idx      = out_idx_q;
  assign underrun_cnt = underrun_cnt_q;
  assign streaming    = (state_q == ST_STREAM);

endmodule

// File: tb/tb_cs_stream_feeder.sv
// tb_cs_stream_feeder: directed bench for cs_stream_feeder with a behavioural
// 3x3 CS filter attached to the main instance and a second, full-start instance
// used to exercise the FIFO-full path.
module tb_cs_stream_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  cs_x;
  logic        cs_rst;
  logic [9:0]  cs_y;
  logic [9:0]  out_y;
  logic        out_valid;
  logic [15:0] out_idx;
  logic [7:0]  underrun_cnt;
  logic        streaming;

  logic [7:0]  f_in_data = 8'd0;
  logic        f_in_valid = 1'b0;
  logic        f_in_ready;
  logic [7:0]  f_cs_x;
  logic        f_cs_rst;
  logic [9:0]  f_out_y;
  logic        f_out_valid;
  logic [15:0] f_out_idx;
  logic [7:0]  f_underrun_cnt;
  logic        f_streaming;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_res = 0;
  int cyc0 = 0;
  int n_rec = 0;
  int w = 0;
  logic [9:0]  res_y [32];
  logic [15:0] res_idx [32];
  int          res_cyc [32];
  logic [7:0]  rec_x [32];
  int          exp_y [12] = '{11, 13, 15, 18, 20, 22, 24, 27, 29, 31, 33, 36};

  always #5 clk = ~clk;

  cs_stream_feeder u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .cs_x(cs_x), .cs_rst(cs_rst), .cs_y(cs_y),
    .out_y(out_y), .out_valid(out_valid), .out_idx(out_idx),
    .underrun_cnt(underrun_cnt), .streaming(streaming)
  );

  cs_stream_feeder #(.DEPTH(16), .START_LEVEL(16)) u_full (
    .clk(clk), .reset(reset), .in_data(f_in_data), .in_valid(f_in_valid),
    .in_ready(f_in_ready), .cs_x(f_cs_x), .cs_rst(f_cs_rst), .cs_y(10'd0),
    .out_y(f_out_y), .out_valid(f_out_valid), .out_idx(f_out_idx),
    .underrun_cnt(f_underrun_cnt), .streaming(f_streaming)
  );

  // Behavioural CS filter: nine-sample window, Y = (sum + 9*appr) >> 3 where
  // appr is the largest window sample not above the integer mean.
  logic [7:0] win_q [9];
  int sum_s, avg_s, appr_s;

  always_ff @(posedge clk) begin
    if (cs_rst) begin
      for (int i = 0; i < 9; i++) win_q[i] <= 8'd0;
    end else begin
      win_q[0] <= cs_x;
      for (int i = 1; i < 9; i++) win_q[i] <= win_q[i-1];
    end
  end

  always_comb begin
    sum_s = 0;
    for (int i = 0; i < 9; i++) sum_s = sum_s + int'(win_q[i]);
    avg_s  = sum_s / 9;
    appr_s = 0;
    for (int i = 0; i < 9; i++) begin
      if ((int'(win_q[i]) <= avg_s) && (int'(win_q[i]) > appr_s)) appr_s = int'(win_q[i]);
    end
    cs_y = 10'((sum_s + 9 * appr_s) >> 3);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_c();
    tick();
    if (out_valid) begin
      if (n_res < 32) begin
        res_y[n_res]   = out_y;
        res_idx[n_res] = out_idx;
        res_cyc[n_res] = cyc;
      end
      n_res++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    vectors++;
    assert (obs === 32'(expv)) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  initial begin
    // Reset cycle and idle state.
    tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("idle_cs_rst", 32'(cs_rst), 1);
    chk("idle_cs_x", 32'(cs_x), 0);
    chk("idle_out_valid", 32'(out_valid), 0);
    chk("idle_in_ready", 32'(in_ready), 1);
    chk("idle_underrun", 32'(underrun_cnt), 0);
    chk("idle_out_idx", 32'(out_idx), 0);
    chk("idle_streaming", 32'(streaming), 0);

    // Nine samples of 10, then stop: one result of 22, then underrun.
    for (int i = 0; i < 9; i++) begin
      in_data = 8'd10; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("t1_idle_at9", 32'(streaming), 0);
    tick();
    chk("t1_stream_on", 32'(streaming), 1);
    chk("t1_cs_rst_low", 32'(cs_rst), 0);
    chk("t1_first_x", 32'(cs_x), 10);
    for (int i = 0; i < 9; i++) tick();
    chk("t1_urun_stream", 32'(streaming), 1);
    chk("t1_urun_x", 32'(cs_x), 0);
    chk("t1_urun_nov", 32'(out_valid), 0);
    tick();
    chk("t1_res_valid", 32'(out_valid), 1);
    chk("t1_res_y", 32'(out_y), 22);
    chk("t1_res_idx", 32'(out_idx), 0);
    chk("t1_idle_again", 32'(streaming), 0);
    chk("t1_cs_rst_high", 32'(cs_rst), 1);
    chk("t1_underrun", 32'(underrun_cnt), 1);
    tick();
    chk("t1_single_pulse", 32'(out_valid), 0);
    chk("t1_idx_after", 32'(out_idx), 1);

    // Continuous 1..20: twelve gap-free results with indices 1..12.
    n_res = 0;
    cyc0 = cyc;
    for (int v = 1; v <= 20; v++) begin
      in_data = 8'(v); in_valid = 1'b1;
      tick_c();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick_c();
    chk("t3_count", 32'(n_res), 12);
    chk("t3_first_cyc", 32'(res_cyc[0]), cyc0 + 20);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t3_y%0d", i), 32'(res_y[i]), exp_y[i]);
      chk($sformatf("t3_idx%0d", i), 32'(res_idx[i]), i + 1);
      if (i > 0) chk($sformatf("t3_cyc%0d", i), 32'(res_cyc[i]), res_cyc[0] + i);
    end
    chk("t3_underrun", 32'(underrun_cnt), 2);
    chk("t3_idle", 32'(streaming), 0);
    chk("t3_idx_end", 32'(out_idx), 13);

    // FIFO full on the START_LEVEL=16 instance; extra push must be refused.
    for (int v = 1; v <= 16; v++) begin
      chk($sformatf("t4_ready%0d", v), 32'(f_in_ready), 1);
      f_in_data = 8'(v); f_in_valid = 1'b1;
      tick();
    end
    f_in_data = 8'd99;
    chk("t4_full_ready", 32'(f_in_ready), 0);
    chk("t4_full_idle", 32'(f_streaming), 0);
    tick();
    chk("t4_full_ready2", 32'(f_in_ready), 0);
    chk("t4_stream_on", 32'(f_streaming), 1);
    f_in_valid = 1'b0;
    n_rec = 0;
    rec_x[n_rec] = f_cs_x; n_rec++;
    tick();
    chk("t4_ready_after_pop", 32'(f_in_ready), 1);
    w = 0;
    while (f_streaming && (w < 30)) begin
      if (n_rec < 32) rec_x[n_rec] = f_cs_x;
      n_rec++;
      tick();
      w++;
    end
    chk("t4_stream_end", 32'(f_streaming), 0);
    chk("t4_rec_count", 32'(n_rec), 17);
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("t4_x%0d", i), 32'(rec_x[i]), (i < 16) ? (i + 1) : 0);
    end
    chk("t4_last_valid", 32'(f_out_valid), 1);
    chk("t4_last_idx", 32'(f_out_idx), 7);
    chk("t4_out_y", 32'(f_out_y), 0);
    chk("t4_underrun", 32'(f_underrun_cnt), 1);
    chk("t4_cs_rst", 32'(f_cs_rst), 1);
    tick();
    chk("t4_idx_final", 32'(f_out_idx), 8);

    // 300 forced underruns: counter saturates at 255.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 9; i++) begin
        in_data = 8'd7; in_valid = 1'b1;
        tick();
      end
      in_valid = 1'b0;
      w = 0;
      while (!streaming && (w < 40)) begin tick(); w++; end
      chk("t5_start", 32'(streaming), 1);
      w = 0;
      while (streaming && (w < 40)) begin tick(); w++; end
      chk("t5_end", 32'(streaming), 0);
    end
    chk("t5_saturated", 32'(underrun_cnt), 255);

    // Reset mid-stream with five entries queued and a result in flight.
    for (int v = 0; v < 20; v++) begin
      in_data = 8'(200 + v); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t6_pre_stream", 32'(streaming), 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_in_ready", 32'(in_ready), 0);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_idle", 32'(streaming), 0);
    chk("t6_cs_rst", 32'(cs_rst), 1);
    chk("t6_cs_x", 32'(cs_x), 0);
    chk("t6_no_valid", 32'(out_valid), 0);
    chk("t6_idx", 32'(out_idx), 0);
    chk("t6_underrun", 32'(underrun_cnt), 0);
    chk("t6_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t6_quiet_v%0d", i), 32'(out_valid), 0);
      chk($sformatf("t6_quiet_s%0d", i), 32'(streaming), 0);
    end
    for (int v = 0; v < 9; v++) begin
      in_data = 8'(50 + v); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("t6_idle_at9", 32'(streaming), 0);
    tick();
    chk("t6_restart", 32'(streaming), 1);
    chk("t6_first_x", 32'(cs_x), 50);
    for (int i = 0; i < 10; i++) tick();
    chk("t6_res_valid", 32'(out_valid), 1);
    chk("t6_res_y", 32'(out_y), 121);
    chk("t6_res_idx", 32'(out_idx), 0);
    chk("t6_underrun2", 32'(underrun_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
